// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and types for the double-buffered VGA frame source
package vga_pkg;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int PAGE_SIZE = FB_W * FB_H;
  localparam int ADDR_W    = 16;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  typedef logic [7:0] rgb332_t;

endpackage

// File: rtl/vga_cell_addr.sv
// rtl/vga_cell_addr.sv - (page, cx, cy) to framebuffer address, row stride 160 via shifts
module vga_cell_addr
  import vga_pkg::*;
(
  input  logic              page,
  input  logic [7:0]        cx,
  input  logic [6:0]        cy,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] row;

  assign base = page ? ADDR_W'(PAGE_SIZE) : '0;
  assign row  = {9'd0, cy};
  // cy*160 = cy*128 + cy*32
  assign addr = base + (row << 7) + (row << 5) + {8'd0, cx};

endmodule

// File: rtl/vga_frame_source.sv
// rtl/vga_frame_source.sv - page-flipped framebuffer reader with host writes and back-page clear
module vga_frame_source #(
  parameter int FB_W       = vga_pkg::FB_W,
  parameter int FB_H       = vga_pkg::FB_H,
  parameter int SCALE_LOG2 = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [9:0]       next_x,
  input  logic [9:0]       next_y,
  input  logic             vsync,
  output vga_pkg::rgb332_t color_out,
  output logic [15:0]      mem_raddr,
  input  vga_pkg::rgb332_t mem_rdata,
  output logic             mem_we,
  output logic [15:0]      mem_waddr,
  output vga_pkg::rgb332_t mem_wdata,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_x,
  input  logic [6:0]       wr_y,
  input  vga_pkg::rgb332_t wr_color,
  input  logic             clr_start,
  input  vga_pkg::rgb332_t clr_color,
  output logic             clr_busy,
  input  logic             swap_req,
  output logic             swap_done,
  output logic             front_page
);

  vga_pkg::clr_state_e state, state_next;
  vga_pkg::rgb332_t    fill;
  logic [7:0]          clr_cx;
  logic [6:0]          clr_cy;
  logic                clr_last;
  logic [10:0]         look_x, cell_x;
  logic [9:0]          cell_y;
  logic [7:0]          rd_cx, wa_cx;
  logic [6:0]          rd_cy, wa_cy;
  logic [15:0]         waddr_calc;
  logic                wr_in_range;
  logic                vsync_q, vsync_fall, swap_pending, swap_fire;

  // +1 lookahead hides the one-cycle RAM read latency
  assign look_x = {1'b0, next_x} + 11'd1;
  assign cell_x = look_x >> SCALE_LOG2;
  assign cell_y = next_y >> SCALE_LOG2;
  assign rd_cx  = (cell_x > 11'(FB_W - 1)) ? 8'(FB_W - 1) : cell_x[7:0];
  assign rd_cy  = (cell_y > 10'(FB_H - 1)) ? 7'(FB_H - 1) : cell_y[6:0];

  vga_cell_addr u_rd_addr (.page(front_page), .cx(rd_cx), .cy(rd_cy), .addr(mem_raddr));

  assign color_out = mem_rdata;

  assign wa_cx       = (state == vga_pkg::ST_CLEAR) ? clr_cx : wr_x;
  assign wa_cy       = (state == vga_pkg::ST_CLEAR) ? clr_cy : wr_y;
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
  assign clr_last    = (clr_cx == 8'(FB_W - 1)) && (clr_cy == 7'(FB_H - 1));

  vga_cell_addr u_wr_addr (.page(~front_page), .cx(wa_cx), .cy(wa_cy), .addr(waddr_calc));

  assign vsync_fall = vsync_q & ~vsync;
  assign swap_fire  = vsync_fall && (swap_pending || swap_req) && (state == vga_pkg::ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= vga_pkg::ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    clr_busy   = 1'b0;
    case (state)
      vga_pkg::ST_IDLE: begin
        wr_ready = ~reset;
        if (clr_start) state_next = vga_pkg::ST_CLEAR;
      end
      vga_pkg::ST_CLEAR: begin
        clr_busy = 1'b1;
        if (clr_last) state_next = vga_pkg::ST_IDLE;
      end
      default: state_next = vga_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      fill         <= '0;
      clr_cx       <= '0;
      clr_cy       <= '0;
      front_page   <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      vsync_q      <= 1'b1;
    end else begin
      vsync_q   <= vsync;
      swap_done <= swap_fire;
      if (swap_fire) begin
        front_page   <= ~front_page;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end

      mem_we <= 1'b0;
      if (state == vga_pkg::ST_CLEAR) begin
        mem_we    <= 1'b1;
        mem_waddr <= waddr_calc;
        mem_wdata <= fill;
        if (clr_cx == 8'(FB_W - 1)) begin
          clr_cx <= '0;
          clr_cy <= clr_cy + 7'd1;
        end else begin
          clr_cx <= clr_cx + 8'd1;
        end
      end else begin
        // A write accepted alongside clr_start is emitted before the first fill cell
        if (wr_valid && wr_ready && wr_in_range) begin
          mem_we    <= 1'b1;
          mem_waddr <= waddr_calc;
          mem_wdata <= wr_color;
        end
        if (clr_start) begin
          fill   <= clr_color;
          clr_cx <= '0;
          clr_cy <= '0;
        end
      end
    end
  end

endmodule
